// File: rtl/tone_gen_pkg.sv
// Shared constants for the DDS voice engine: register map, wave types,
// FSM states, duty-pattern table and noise LFSR settings.
package tone_gen_pkg;

  localparam logic [1:0] REG_INCR = 2'd0;
  localparam logic [1:0] REG_VOL  = 2'd1;
  localparam logic [1:0] REG_WAVE = 2'd2;
  localparam logic [1:0] REG_RATE = 2'd3;

  localparam logic [2:0] WAVE_D50 = 3'd0;
  localparam logic [2:0] WAVE_D12 = 3'd1;
  localparam logic [2:0] WAVE_D25 = 3'd2;
  localparam logic [2:0] WAVE_D37 = 3'd3;
  localparam logic [2:0] WAVE_D62 = 3'd4;
  localparam logic [2:0] WAVE_D75 = 3'd5;
  localparam logic [2:0] WAVE_D87 = 3'd6;
  localparam logic [2:0] WAVE_ALT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PHASE,
    ST_MIX,
    ST_DONE
  } state_t;

  // Row w is wave type w; the row's MSB is phase index 0.
  localparam logic [7:0][7:0] DUTY_LUT = {
    8'b00011001, 8'b01111111, 8'b00111111, 8'b00011111,
    8'b00000111, 8'b00000011, 8'b00000001, 8'b00001111
  };

  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  function automatic logic duty_bit(input logic [2:0] wtype, input logic [2:0] ph);
    logic [7:0] row;
    row = DUTY_LUT[wtype];
    return row[3'd7 - ph];
  endfunction

endpackage

// File: rtl/sat_add_w.sv
// Signed adder of parametrised width; clamps to the most positive or most
// negative value on overflow when sat_en is high, otherwise wraps.
module sat_add_w #(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sat_en,
  output logic signed [W-1:0] y
);

  logic [W:0] full;

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    y    = full[W-1:0];
    if (sat_en && (full[W] != full[W-1])) begin
      y = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dds_voice_engine.sv
// NUM_CH-voice DDS engine: phase/envelope update then saturating mix, once per
// sample tick. Define NOISE_WAVE_EN to make wave type 7 an LFSR noise source.
module dds_voice_engine
  import tone_gen_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 4,
  parameter  int unsigned ACC_W     = 16,
  parameter  int unsigned VOL_W     = 8,
  parameter  int unsigned OUT_W     = 16,
  parameter  int unsigned MIX_SHIFT = 2,
  localparam int unsigned CH_AW     = $clog2(NUM_CH)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             sample_tick_in,
  input  logic [ACC_W-1:0] data_in,
  input  logic [CH_AW+1:0] addr_in,
  input  logic             data_valid_in,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid_out,
  output logic             busy_out,
  output logic             overrun_out
);

  state_t state, state_nxt;
  logic [CH_AW-1:0] idx;
  logic             last_idx;
  logic             tick_accept;

  logic [ACC_W-1:0] sh_incr [NUM_CH];
  logic [VOL_W-1:0] sh_vol  [NUM_CH];
  logic [2:0]       sh_wave [NUM_CH];
  logic [VOL_W-1:0] sh_rate [NUM_CH];
  logic [ACC_W-1:0] a_incr  [NUM_CH];
  logic [VOL_W-1:0] a_vol   [NUM_CH];
  logic [2:0]       a_wave  [NUM_CH];
  logic [VOL_W-1:0] a_rate  [NUM_CH];
  logic [ACC_W-1:0] acc     [NUM_CH];
  logic [VOL_W-1:0] env     [NUM_CH];
  logic [NUM_CH-1:0] wave_bit;

  logic [ACC_W-1:0]        acc_nxt;
  logic [VOL_W-1:0]        env_nxt;
  logic [VOL_W:0]          env_up;
  logic                    wave_nxt;
  logic [OUT_W-1:0]        amp;
  logic signed [OUT_W-1:0] mix_raw, mix_v, sum, sum_nxt;

  assign last_idx    = (idx == CH_AW'(NUM_CH - 1));
  assign tick_accept = (state == ST_IDLE) && sample_tick_in;
  assign busy_out    = (state != ST_IDLE);
  assign overrun_out = sample_tick_in && (state != ST_IDLE);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (sample_tick_in) state_nxt = ST_PHASE;
      ST_PHASE: if (last_idx) state_nxt = ST_MIX;
      ST_MIX:   if (last_idx) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sh_incr[i] <= '0;
        sh_vol[i]  <= '0;
        sh_wave[i] <= '0;
        sh_rate[i] <= '0;
      end
    end else if (data_valid_in) begin
      unique case (addr_in[CH_AW+1:CH_AW])
        REG_INCR: sh_incr[addr_in[CH_AW-1:0]] <= data_in;
        REG_VOL:  sh_vol[addr_in[CH_AW-1:0]]  <= data_in[VOL_W-1:0];
        REG_WAVE: sh_wave[addr_in[CH_AW-1:0]] <= data_in[2:0];
        REG_RATE: sh_rate[addr_in[CH_AW-1:0]] <= data_in[VOL_W-1:0];
        default:  ;
      endcase
    end
  end

`ifdef NOISE_WAVE_EN
  logic [14:0]       lfsr;
  logic [NUM_CH-1:0] noise_bit;
  logic              carry, noise_nxt;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) lfsr <= LFSR_SEED;
    else             lfsr <= {lfsr[13:0], ^(lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)              noise_bit      <= '0;
    else if (state == ST_PHASE)   noise_bit[idx] <= noise_nxt;
  end
`endif

  // Phase, envelope and wave-bit update for the voice selected by idx.
  always_comb begin
`ifdef NOISE_WAVE_EN
    {carry, acc_nxt} = {1'b0, acc[idx]} + {1'b0, a_incr[idx]};
    noise_nxt        = carry ? lfsr[0] : noise_bit[idx];
    wave_nxt         = (a_wave[idx] == WAVE_ALT) ? noise_nxt
                     : duty_bit(a_wave[idx], acc_nxt[ACC_W-1 -: 3]);
`else
    acc_nxt  = acc[idx] + a_incr[idx];
    wave_nxt = duty_bit(a_wave[idx], acc_nxt[ACC_W-1 -: 3]);
`endif
    env_up  = {1'b0, env[idx]} + {1'b0, a_rate[idx]};
    env_nxt = env[idx];
    if (a_rate[idx] == '0) begin
      env_nxt = a_vol[idx];
    end else if (env[idx] < a_vol[idx]) begin
      env_nxt = (env_up > {1'b0, a_vol[idx]}) ? a_vol[idx] : env_up[VOL_W-1:0];
    end else if (env[idx] > a_vol[idx]) begin
      env_nxt = ((env[idx] < a_rate[idx]) || ((env[idx] - a_rate[idx]) < a_vol[idx]))
              ? a_vol[idx] : (env[idx] - a_rate[idx]);
    end
  end

  // Envelope bits repeat MSB-first across the positive magnitude field.
  always_comb begin
    amp = '0;
    for (int unsigned j = 0; j < OUT_W - 1; j++) begin
      amp[OUT_W-2-j] = env[idx][VOL_W-1-(j % VOL_W)];
    end
    mix_raw = wave_bit[idx] ? amp : ~amp;
    mix_v   = mix_raw >>> MIX_SHIFT;
  end

  sat_add_w #(.W(OUT_W)) u_mix_add (
    .a      (sum),
    .b      (mix_v),
    .sat_en (1'b1),
    .y      (sum_nxt)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      idx            <= '0;
      sum            <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      wave_bit       <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        a_incr[i] <= '0;
        a_vol[i]  <= '0;
        a_wave[i] <= '0;
        a_rate[i] <= '0;
        acc[i]    <= '0;
        env[i]    <= '0;
      end
    end else begin
      data_valid_out <= 1'b0;
      if (tick_accept) begin
        idx    <= '0;
        sum    <= '0;
        a_incr <= sh_incr;
        a_vol  <= sh_vol;
        a_wave <= sh_wave;
        a_rate <= sh_rate;
      end
      if (state == ST_PHASE || state == ST_MIX) begin
        idx <= last_idx ? '0 : idx + 1'b1;
      end
      if (state == ST_PHASE) begin
        acc[idx]      <= acc_nxt;
        env[idx]      <= env_nxt;
        wave_bit[idx] <= wave_nxt;
      end
      if (state == ST_MIX) begin
        sum <= sum_nxt;
        if (last_idx) begin
          data_out       <= sum_nxt;
          data_valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_voice_engine.sv
// Directed bench for dds_voice_engine: default instance plus a MIX_SHIFT=0
// instance sharing the same stimulus for the saturation cases.
module tb_dds_voice_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  addr = '0;
  logic        dvalid = 1'b0;

  logic [15:0] dout, s0_dout;
  logic        dv, busy, ovr, s0_dv, s0_busy, s0_ovr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_voice_engine dut (
    .clk_in(clk), .reset_n_in(rst_n), .sample_tick_in(tick), .data_in(din),
    .addr_in(addr), .data_valid_in(dvalid), .data_out(dout),
    .data_valid_out(dv), .busy_out(busy), .overrun_out(ovr)
  );

  dds_voice_engine #(.MIX_SHIFT(0)) dut_s0 (
    .clk_in(clk), .reset_n_in(rst_n), .sample_tick_in(tick), .data_in(din),
    .addr_in(addr), .data_valid_in(dvalid), .data_out(s0_dout),
    .data_valid_out(s0_dv), .busy_out(s0_busy), .overrun_out(s0_ovr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] rtype, input logic [1:0] voice, input logic [15:0] val);
    @(negedge clk);
    addr   = {rtype, voice};
    din    = val;
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One frame; returns both mixes, checks the valid pulse lands 9 cycles after the tick.
  task automatic run_frame(input string tag, output logic [15:0] res, output logic [15:0] res_s0);
    int lat;
    lat    = 0;
    res    = 'x;
    res_s0 = 'x;
    @(negedge clk);
    tick = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) tick = 1'b0;
      if (dv) begin
        lat    = k;
        res    = dout;
        res_s0 = s0_dout;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, 9);
    @(negedge clk);
  endtask

  function automatic logic [15:0] low_mix(input logic [7:0] e);
    logic signed [15:0] amp, v;
    amp = {1'b0, e, e[7:1]};
    v   = ~amp;
    v   = v >>> 2;
    return v - 16'sd3;
  endfunction

  logic [15:0] r, r0;
  logic [15:0] t1 [8] = '{16'hDFFD, 16'hDFFD, 16'hDFFD, 16'h1FFC,
                          16'h1FFC, 16'h1FFC, 16'h1FFC, 16'hDFFD};
  int unsigned e;
  int vcount;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_dout", dout, 16'h0);
    check_eq("rst_dv", dv, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr", ovr, 0);
    rst_n = 1'b1;

    // All registers zero: each voice contributes -1
    run_frame("zero", r, r0);
    check_eq("zero_dout", r, 16'hFFFC);
    repeat (2) @(negedge clk);
    check_eq("zero_hold", dout, 16'hFFFC);

    // Voice 0 square sweep
    do_reset();
    wr(2'd0, 2'd0, 16'h2000);
    wr(2'd1, 2'd0, 16'h00FF);
    for (int f = 0; f < 8; f++) begin
      run_frame("sq", r, r0);
      check_eq($sformatf("sq_f%0d", f + 1), r, t1[f]);
    end

    // Envelope ramp up to 0x80 at rate 0x10, then down to 0
    do_reset();
    wr(2'd1, 2'd0, 16'h0080);
    wr(2'd3, 2'd0, 16'h0010);
    for (int f = 1; f <= 10; f++) begin
      e = (16 * f > 128) ? 128 : 16 * f;
      run_frame("envup", r, r0);
      check_eq($sformatf("envup_f%0d", f), r, low_mix(8'(e)));
    end
    wr(2'd1, 2'd0, 16'h0000);
    for (int f = 1; f <= 9; f++) begin
      e = (16 * f > 128) ? 0 : 128 - 16 * f;
      run_frame("envdn", r, r0);
      check_eq($sformatf("envdn_f%0d", f), r, low_mix(8'(e)));
    end

    // Saturation: four full-scale voices high then low
    do_reset();
    for (int v = 0; v < 4; v++) begin
      wr(2'd0, 2'(v), 16'h8000);
      wr(2'd1, 2'(v), 16'h00FF);
    end
    run_frame("sat_hi", r, r0);
    check_eq("sat_hi_s2", r, 16'h7FFC);
    check_eq("sat_hi_s0", r0, 16'h7FFF);
    run_frame("sat_lo", r, r0);
    check_eq("sat_lo_s2", r, 16'h8000);
    check_eq("sat_lo_s0", r0, 16'h8000);

    // Overrun while busy and in DONE; incr write during frame deferred
    do_reset();
    wr(2'd1, 2'd0, 16'h00FF);
    vcount = 0;
    r = '0;
    @(negedge clk);
    tick = 1'b1;
    #1 check_eq("ovr_accept", ovr, 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tick   = 1'b0;
      dvalid = 1'b0;
      if (dv) begin
        vcount++;
        r = dout;
      end
      if (k == 2) check_eq("busy_mid", busy, 1);
      if (k == 2) check_eq("ovr_quiet", ovr, 0);
      if (k == 3) begin
        tick   = 1'b1;
        addr   = {2'd0, 2'd0};
        din    = 16'h8000;
        dvalid = 1'b1;
        #1 check_eq("ovr_busy", ovr, 1);
      end
      if (k == 9) begin
        tick = 1'b1;
        #1 check_eq("ovr_done", ovr, 1);
      end
    end
    check_eq("ovr_vcount", vcount, 1);
    check_eq("ovr_dout", r, 16'hDFFD);
    run_frame("ovr_next", r, r0);
    check_eq("ovr_next_dout", r, 16'h1FFC);

    // Reset in the middle of MIX
    do_reset();
    wr(2'd0, 2'd0, 16'h2000);
    wr(2'd1, 2'd0, 16'h00FF);
    run_frame("pre", r, r0);
    check_eq("pre_dout", r, 16'hDFFD);
    @(negedge clk);
    tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tick = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_dout", dout, 16'h0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_dv", dv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (dv) vcount++;
    end
    check_eq("abort_novalid", vcount, 0);
    run_frame("post", r, r0);
    check_eq("post_dout", r, 16'hFFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_voice_engine.md
Name: dds_voice_engine

Overview:
Parametrised successor to the 4-voice DDS sample engine. It runs NUM_CH phase-accumulator voices, each with a duty-pattern waveform and a per-voice linear volume envelope. Voices are mixed with configurable pre-attenuation and saturation into one signed sample per frame. It sits between the register-write bus and the PWM/DAC output stage, and an external sample_tick_in starts each frame.

Parameters:
NUM_CH, 4, voice count; power of two, 2..16; CH_AW = log2(NUM_CH)
ACC_W, 16, phase accumulator and increment width, 12..24; also the data_in width
VOL_W, 8, volume/envelope width, 4..OUT_W-1
OUT_W, 16, signed mix output width
MIX_SHIFT, 2, arithmetic right shift applied to each voice before mixing, 0..CH_AW

Ports:
clk_in  input  1  clock
reset_n_in  input  1  reset, asynchronous assert, active-low
sample_tick_in  input  1  one-cycle frame start strobe
data_in  input  ACC_W  register write data
addr_in  input  CH_AW+2  [CH_AW+1:CH_AW] = register type, [CH_AW-1:0] = voice
data_valid_in  input  1  register write strobe
data_out  output  OUT_W  signed mixed sample, held between frames
data_valid_out  output  1  one-cycle pulse when data_out updates
busy_out  output  1  high while a frame is in progress
overrun_out  output  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (async, reset_n_in=0): all outputs 0; accumulators, envelopes, shadow and active registers 0; FSM to IDLE.
- Register types: 0 = phase increment [ACC_W-1:0]; 1 = target volume [VOL_W-1:0]; 2 = wave type [2:0]; 3 = envelope rate [VOL_W-1:0].
- Writes land in shadow registers in the cycle after data_valid_in.
- The shadow is copied to active registers on the cycle a tick is accepted. A write in that same cycle goes to the shadow only and takes effect in the next frame.
- FSM states and transitions:
  - IDLE: goes to PHASE when sample_tick_in is high.
  - PHASE: NUM_CH cycles, voice i on cycle i.
  - MIX: NUM_CH cycles.
  - DONE: 1 cycle, then IDLE.
- busy_out = state != IDLE.
- data_valid_out pulses in DONE. It is registered with data_out, 2*NUM_CH+1 cycles after the accepted tick.
- PHASE, voice i:
  - acc[i] <= acc[i] + incr[i], modulo 2^ACC_W.
  - Envelope steps toward target: env = min(env+rate, target) when below, max(env-rate, target) when above. Rate 0 loads target immediately.
  - wave bit latched from the updated acc[ACC_W-1 -: 3] via the duty LUT:
    - type 0 = 00001111, 1 = 00000001, 2 = 00000011, 3 = 00000111
    - type 4 = 00011111, 5 = 00111111, 6 = 01111111, 7 = 00011001
    - LUT bit k corresponds to phase index k, MSB-first in the strings above.
- MIX, voice i:
  - amp = {0, env replicated MSB-first to OUT_W-1 bits}.
  - v = wave ? amp : ~amp, then arithmetic shift right by MIX_SHIFT.
  - sum starts at 0 and accumulates v with signed saturation to 0x7FFF/0x8000 (OUT_W=16 case). Saturation is applied at each step.
- Tick while busy: ignored, the frame continues unaffected, overrun_out pulses in the same cycle.
- Tick in DONE: also counts as an overrun.
- Reset mid-frame: immediate abort, all state cleared, no data_valid_out.

Optional Feature:
NOISE_WAVE_EN
- Defined: wave type 7 selects noise instead of the 00011001 pattern.
  - 15-bit LFSR (x^15+x^14+1), seeded 15'h0001 at reset, advances every clock.
  - A voice's noise bit reloads from LFSR bit 0 in its PHASE cycle whenever its accumulator carries out. That bit is the voice's wave bit.
- Undefined: LFSR and noise registers absent; type 7 = 00011001.

Decomposition:
- Package tone_gen_pkg holds:
  - register type codes REG_INCR/REG_VOL/REG_WAVE/REG_RATE
  - wave type constants
  - FSM state enum
  - the duty LUT constant table
  - the LFSR seed and taps
- One sub-module, sat_add_w: parametrised-width signed saturating adder with saturation enable. Used for the mix.

Test Plan:
- Reset, all regs 0, one tick. Every voice low with amp 0, so v = -1 each → data_out = 0xFFFC (NUM_CH=4, MIX_SHIFT=2), data_valid_out pulse 9 cycles after the tick.
- Voice 0: incr 0x2000, vol 0xFF, rate 0, type 0; others vol 0. Frames 1-3 give 0xDFFD, frames 4-7 give 0x1FFC, frame 8 gives 0xDFFD (acc wraps to 0).
- Voice 0: target 0x80, rate 0x10. Env reads 0x10, 0x20 … 0x80 over frames 1-8 and holds at 0x80 from frame 9. Target then set to 0x00 → env 0x70, 0x60 … down to 0.
- MIX_SHIFT=0, four voices vol 0xFF, all wave high → data_out = 0x7FFF (saturated). All wave low → 0x8000.
- Tick 3 cycles into a frame → overrun_out one-cycle pulse, single data_valid_out. An incr write during busy is not applied this frame and is applied next frame.
- reset_n_in low mid-MIX → outputs 0 immediately, no valid pulse. The next tick yields the same result as after power-on reset.
